// File: rtl/dbf_apod_stage.sv
// Dynamic-apodization stage for one beamformer channel.
// Each focused sample from the fine-delay stage is weighted by a coefficient
// from a local LUT. The LUT read pointer advances once per accepted sample and
// stops on the last entry. The product is rounded, shifted, saturated and
// registered onto the channel output. Data latency is fixed at three cycles.
module dbf_apod_stage #(
  parameter int unsigned DIN_WD    = 18,
  parameter int unsigned APO_WD    = 16,
  parameter int unsigned DOUT_WD   = 32,
  parameter int unsigned SHIFT     = 2,
  parameter int unsigned ADDR_WD   = 10,
  parameter int unsigned LUT_DEPTH = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WD-1:0]        lut_addr,
  input  logic                      lut_we,
  input  logic signed [APO_WD-1:0]  apo_din,
  input  logic signed [DIN_WD-1:0]  fd_din,
  input  logic                      fd_din_valid,
  output logic signed [DOUT_WD-1:0] dbf_dout,
  output logic                      dbf_dout_valid,
  output logic                      apo_done
);

  localparam int unsigned ProdWd = DIN_WD + APO_WD;
  // One extra bit so the rounding constant cannot overflow the sum.
  localparam int unsigned SumWd  = ProdWd + 1;
  localparam int unsigned ExtWd  = (SumWd > DOUT_WD) ? SumWd : DOUT_WD;
  localparam int unsigned IdxWd  = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam int unsigned RndPos = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [IdxWd-1:0]          LastIdx  = IdxWd'(LUT_DEPTH - 1);
  localparam logic [ADDR_WD:0]          DepthLim = (ADDR_WD + 1)'(LUT_DEPTH);
  localparam logic signed [SumWd-1:0]   RndAdd   = (SHIFT > 0) ? (SumWd'(1) << RndPos) : '0;
  localparam logic signed [DOUT_WD-1:0] OutMax   = {1'b0, {(DOUT_WD - 1){1'b1}}};
  localparam logic signed [DOUT_WD-1:0] OutMin   = {1'b1, {(DOUT_WD - 1){1'b0}}};
  localparam logic signed [ExtWd-1:0]   ExtMax   = ExtWd'(OutMax);
  localparam logic signed [ExtWd-1:0]   ExtMin   = ExtWd'(OutMin);

  typedef enum logic [1:0] {StIdle, StActive, StHold} state_e;

  state_e                     state_q;
  logic                       start_q;
  logic [IdxWd-1:0]           rd_ptr_q;
  logic                       apo_done_q;

  logic signed [APO_WD-1:0]   mem [LUT_DEPTH];

  logic                       accept;
  logic                       flush;
  logic                       lut_wr_en;

  logic                       s1_vld_q;
  logic signed [DIN_WD-1:0]   s1_din_q;
  logic signed [APO_WD-1:0]   s1_coef_q;
  logic                       s2_vld_q;
  logic signed [ProdWd-1:0]   s2_prod_q;
  logic                       dout_vld_q;
  logic signed [DOUT_WD-1:0]  dout_q;

  logic signed [SumWd-1:0]    rnd_sum;
  logic signed [SumWd-1:0]    rnd_shift;
  logic signed [ExtWd-1:0]    rnd_ext;
  logic signed [DOUT_WD-1:0]  sat_val;

  // Samples are taken only inside an open receive window; dropping start
  // flushes everything still in flight on the same edge.
  assign accept    = fd_din_valid && start && (state_q != StIdle);
  assign flush     = !start;
  assign lut_wr_en = lut_we && (state_q == StIdle) && ({1'b0, lut_addr} < DepthLim);

  // Control FSM: receive-window tracking, LUT pointer and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      // Reset to 1 so a start held high through reset is not taken as a new edge.
      start_q    <= 1'b1;
      rd_ptr_q   <= '0;
      apo_done_q <= 1'b0;
    end else begin
      start_q <= start;
      unique case (state_q)
        StIdle: begin
          apo_done_q <= 1'b0;
          if (start && !start_q) begin
            state_q  <= StActive;
            rd_ptr_q <= '0;
          end
        end
        StActive: begin
          if (!start) begin
            state_q <= StIdle;
          end else if (fd_din_valid) begin
            if (rd_ptr_q == LastIdx) begin
              state_q    <= StHold;
              apo_done_q <= 1'b1;
            end else begin
              rd_ptr_q <= rd_ptr_q + IdxWd'(1);
            end
          end
        end
        StHold: begin
          if (!start) begin
            state_q    <= StIdle;
            apo_done_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          apo_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient LUT write port; only open while idle.
  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      mem[lut_addr[IdxWd-1:0]] <= apo_din;
    end
  end

  // Round half up, arithmetic shift, then clamp into the output range.
  always_comb begin
    rnd_sum   = {s2_prod_q[ProdWd-1], s2_prod_q} + RndAdd;
    rnd_shift = rnd_sum >>> SHIFT;
    rnd_ext   = ExtWd'(rnd_shift);
    sat_val   = rnd_ext[DOUT_WD-1:0];
    if (rnd_ext > ExtMax) begin
      sat_val = OutMax;
    end else if (rnd_ext < ExtMin) begin
      sat_val = OutMin;
    end
  end

  // Three-stage datapath: capture/LUT read, multiply, round+saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_din_q   <= '0;
      s1_coef_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_prod_q  <= '0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_din_q  <= fd_din;
        s1_coef_q <= mem[rd_ptr_q];
      end
      s2_vld_q   <= s1_vld_q && !flush;
      s2_prod_q  <= ProdWd'(s1_din_q) * ProdWd'(s1_coef_q);
      dout_vld_q <= s2_vld_q && !flush;
      dout_q     <= (s2_vld_q && !flush) ? sat_val : '0;
    end
  end

  assign dbf_dout       = dout_q;
  assign dbf_dout_valid = dout_vld_q;
  assign apo_done       = apo_done_q;

endmodule

// File: tb/tb_dbf_apod_stage.sv
// Directed bench for dbf_apod_stage. Three instances share one stimulus:
// default parameters, a 4-entry LUT, and SHIFT=0 for the saturation corners.
module tb_dbf_apod_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start;
  logic [9:0]         lut_addr;
  logic               lut_we;
  logic signed [15:0] apo_din;
  logic signed [17:0] fd_din;
  logic               fd_din_valid;

  logic signed [31:0] dout_m, dout_h, dout_s;
  logic               vld_m, vld_h, vld_s;
  logic               done_m, done_h, done_s;

  int checks   = 0;
  int failures = 0;

  dbf_apod_stage u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .lut_addr(lut_addr), .lut_we(lut_we),
    .apo_din(apo_din), .fd_din(fd_din), .fd_din_valid(fd_din_valid),
    .dbf_dout(dout_m), .dbf_dout_valid(vld_m), .apo_done(done_m)
  );

  dbf_apod_stage #(.LUT_DEPTH(4)) u_hold (
    .clk(clk), .rst_n(rst_n), .start(start), .lut_addr(lut_addr), .lut_we(lut_we),
    .apo_din(apo_din), .fd_din(fd_din), .fd_din_valid(fd_din_valid),
    .dbf_dout(dout_h), .dbf_dout_valid(vld_h), .apo_done(done_h)
  );

  dbf_apod_stage #(.SHIFT(0)) u_shift0 (
    .clk(clk), .rst_n(rst_n), .start(start), .lut_addr(lut_addr), .lut_we(lut_we),
    .apo_din(apo_din), .fd_din(fd_din), .fd_din_valid(fd_din_valid),
    .dbf_dout(dout_s), .dbf_dout_valid(vld_s), .apo_done(done_s)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Check valid and data of one instance: 0 main, 1 hold, 2 shift0.
  task automatic ck(input int which, input string tag, input logic ev, input int ed);
    case (which)
      1: begin chk({tag, ".v"}, vld_h, ev); chk({tag, ".d"}, dout_h, ed); end
      2: begin chk({tag, ".v"}, vld_s, ev); chk({tag, ".d"}, dout_s, ed); end
      default: begin chk({tag, ".v"}, vld_m, ev); chk({tag, ".d"}, dout_m, ed); end
    endcase
  endtask

  task automatic drv(input logic v, input int d);
    fd_din_valid = v;
    fd_din       = 18'(d);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    lut_we   = 1'b1;
    lut_addr = 10'(a);
    apo_din  = 16'(d);
    @(negedge clk);
    lut_we   = 1'b0;
  endtask

  task automatic stop();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; lut_we = 1'b0; lut_addr = '0; apo_din = '0;
    fd_din = '0; fd_din_valid = 1'b0;
    repeat (2) @(negedge clk);
    ck(0, "reset", 1'b0, 0);
    chk("reset.done", done_m, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic weighting
    wr(0, 16384); wr(1, 32767); wr(2, -16384); wr(3, 0);
    go();
    drv(1, 1000); ck(0, "bw_lat0", 0, 0);
    drv(1, 1000); ck(0, "bw_lat1", 0, 0);
    drv(1, 1000); ck(0, "bw0", 1, 4096000);
    drv(1, 1000); ck(0, "bw1", 1, 8191750);
    drv(0, 0);    ck(0, "bw2", 1, -4096000);
    drv(0, 0);    ck(0, "bw3", 1, 0);
    drv(0, 0);    ck(0, "bw_end", 0, 0);

    // Samples while idle are dropped
    stop();
    drv(1, 500); drv(1, 500); drv(0, 0);
    ck(0, "idle_drop", 0, 0);

    // Valid gaps
    wr(0, 8192); wr(1, -8192);
    go();
    drv(1, 400); ck(0, "gap_a", 0, 0);
    drv(0, 0);   ck(0, "gap_b", 0, 0);
    drv(0, 0);   ck(0, "gap0", 1, 819200);
    drv(1, 400); ck(0, "gap_c", 0, 0);
    drv(0, 0);   ck(0, "gap_d", 0, 0);
    drv(0, 0);   ck(0, "gap1", 1, -819200);
    drv(0, 0);   ck(0, "gap_end", 0, 0);

    // HOLD on the 4-entry instance; address 4 is out of range for it
    stop();
    wr(3, 12345); wr(4, 777);
    go();
    drv(1, 4); ck(1, "hold_a", 0, 0);
    drv(1, 4); ck(1, "hold_b", 0, 0);
    drv(1, 4); ck(1, "hold0", 1, 8192);   chk("hold.done_pre", done_h, 0);
    drv(1, 4); ck(1, "hold1", 1, -8192);  chk("hold.done_set", done_h, 1);
    drv(1, 4); ck(1, "hold2", 1, -16384);
    drv(1, 4); ck(1, "hold3", 1, 12345);
    drv(0, 0); ck(1, "hold4", 1, 12345);  chk("hold.main_done", done_m, 0);
    drv(0, 0); ck(1, "hold5", 1, 12345);
    drv(0, 0); ck(1, "hold_end", 0, 0);
    stop();
    chk("hold.done_clr", done_h, 0);

    // Saturation corners
    wr(0, -32768); wr(1, -32768);
    go();
    drv(1, -131072); ck(0, "sat_a", 0, 0);
    drv(1, 131071);  ck(0, "sat_b", 0, 0);
    drv(0, 0); ck(0, "sat_pos", 1, 1073741824); ck(2, "sat0_pos", 1, 2147483647);
    drv(0, 0); ck(0, "sat_neg", 1, -1073733632); ck(2, "sat0_neg", 1, 32'sh8000_0000);

    // LUT write while active is ignored; start drop flushes in-flight samples
    wr(0, 1234);
    drv(1, 100); ck(0, "drop_a", 0, 0);
    drv(1, 100); ck(0, "drop_b", 0, 0);
    start = 1'b0;
    drv(1, 100); ck(0, "drop0", 0, 0);
    drv(0, 0);   ck(0, "drop1", 0, 0);
    drv(0, 0);   ck(0, "drop2", 0, 0);
    go();
    drv(1, 4); ck(0, "wrblk_a", 0, 0);
    drv(0, 0); ck(0, "wrblk_b", 0, 0);
    drv(0, 0); ck(0, "wrblk", 1, -32768);

    // Asynchronous reset mid-stream, start held high across release
    drv(1, 1000); drv(1, 1000); drv(1, 1000);
    ck(0, "pre_rst", 1, -8192000);
    rst_n = 1'b0;
    #1;
    ck(0, "async_rst", 0, 0);
    chk("async_rst.done", done_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(1, 1000);
      ck(0, "post_rst", 0, 0);
    end
    fd_din_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
